// File: rtl/err_compute_n_if.sv
// -----------------------------------------------------------------------------
// err_compute_n_if
// Bundles the IR reading handshake and the error/status outputs of
// err_compute_n. The clock and reset are not part of the bundle.
//   IR_vld       one-cycle strobe: a new reading set is on IR_R/IR_L
//   IR_R, IR_L   packed right/left readings, pair i at [i*IR_W +: IR_W]
//   err_opn_lp   signed open-loop steering term used when no line is seen
//   err_raw      signed, saturated, weighted IR error
//   error        err_raw when a line is present, else err_opn_lp
//   line_present line detected in the last completed set
//   err_vld      one-cycle pulse when the three result outputs update
//   busy         a set is being processed
//   overrun      sticky: IR_vld arrived while busy
// slave  = the error computer, master = whoever supplies readings.
// -----------------------------------------------------------------------------
interface err_compute_n_if #(
  parameter int NUM_PAIRS = 4,
  parameter int IR_W      = 12,
  parameter int ERR_W     = 16
) ();
  logic                      IR_vld;
  logic [NUM_PAIRS*IR_W-1:0] IR_R;
  logic [NUM_PAIRS*IR_W-1:0] IR_L;
  logic [ERR_W-1:0]          err_opn_lp;
  logic [ERR_W-1:0]          err_raw;
  logic [ERR_W-1:0]          error;
  logic                      line_present;
  logic                      err_vld;
  logic                      busy;
  logic                      overrun;

  modport slave (
    input  IR_vld, IR_R, IR_L, err_opn_lp,
    output err_raw, error, line_present, err_vld, busy, overrun
  );

  modport master (
    output IR_vld, IR_R, IR_L, err_opn_lp,
    input  err_raw, error, line_present, err_vld, busy, overrun
  );
endinterface

// File: rtl/err_compute_n.sv
// -----------------------------------------------------------------------------
// err_compute_n
// Turns NUM_PAIRS left/right IR readings into a steering error. Each set is
// captured, then accumulated one pair per cycle:
//   acc += (R[i] - L[i]) << i      sum += R[i] + L[i]
// and the result is saturated to ERR_W bits. When the summed intensity is
// above LINE_THRES a line is present and error follows err_raw; otherwise
// error follows the open-loop term.
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  synchronous, active-low reset
//   bus    err_compute_n_if.slave (readings in, error/status out)
// Latency: IR_vld in cycle T -> err_vld in cycle T+NUM_PAIRS+2.
// -----------------------------------------------------------------------------
module err_compute_n #(
  parameter int          NUM_PAIRS  = 4,
  parameter int          IR_W       = 12,
  parameter int          ERR_W      = 16,
  parameter logic [15:0] LINE_THRES = 16'h0200
) (
  input  logic           clk,
  input  logic           rst_n,
  err_compute_n_if.slave bus
);

  localparam int ACC_W  = IR_W + NUM_PAIRS + 2;
  localparam int SUM_W  = IR_W + 5;
  localparam int IDX_W  = $clog2(NUM_PAIRS);
  localparam int WIDE_W = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CAPT  = 2'd1;
  localparam logic [1:0] ACCUM = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // ERR_W signed limits, widened so the comparison never truncates acc.
  localparam logic signed [WIDE_W-1:0] SAT_MAX =
    {{(WIDE_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_MIN =
    {{(WIDE_W-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};
  localparam logic [31:0] THRES32 = {16'h0000, LINE_THRES};

  logic [1:0]                r_state;
  logic [NUM_PAIRS*IR_W-1:0] r_shadow_r;
  logic [NUM_PAIRS*IR_W-1:0] r_shadow_l;
  logic signed [ACC_W-1:0]   r_acc;
  logic [SUM_W-1:0]          r_sum;
  logic [IDX_W-1:0]          r_idx;
  logic [ERR_W-1:0]          r_err_raw;
  logic [ERR_W-1:0]          r_error;
  logic                      r_line_present;
  logic                      r_err_vld;
  logic                      r_overrun;

  logic [IR_W-1:0]           w_r_pair;
  logic [IR_W-1:0]           w_l_pair;
  logic [IR_W:0]             w_diff;
  logic signed [ACC_W-1:0]   w_term;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic [SUM_W-1:0]          w_sum_next;
  logic signed [WIDE_W-1:0]  w_acc_wide;
  logic [ERR_W-1:0]          w_err_raw_next;
  logic                      w_line_next;
  logic [ERR_W-1:0]          w_error_next;
  logic                      w_last;

  // Datapath for the pair selected by r_idx. The result of the final pair
  // is registered straight into the outputs, so err_vld and the new values
  // appear together in DONE.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    w_r_pair       = r_shadow_r[int'(r_idx)*IR_W +: IR_W];
    w_l_pair       = r_shadow_l[int'(r_idx)*IR_W +: IR_W];
    w_diff         = {1'b0, w_r_pair} - {1'b0, w_l_pair};
    w_term         = {{(ACC_W-IR_W-1){w_diff[IR_W]}}, w_diff} <<< r_idx;
    w_acc_next     = r_acc + w_term;
    w_sum_next     = r_sum + SUM_W'(w_r_pair) + SUM_W'(w_l_pair);
    w_acc_wide     = {{(WIDE_W-ACC_W){w_acc_next[ACC_W-1]}}, w_acc_next};
    w_err_raw_next = w_acc_wide[ERR_W-1:0];
    if (w_acc_wide > SAT_MAX) w_err_raw_next = SAT_MAX[ERR_W-1:0];
    if (w_acc_wide < SAT_MIN) w_err_raw_next = SAT_MIN[ERR_W-1:0];
    // Strictly greater: a sum equal to the threshold means no line.
    w_line_next    = 32'(w_sum_next) > THRES32;
    w_error_next   = w_line_next ? w_err_raw_next : bus.err_opn_lp;
    w_last         = (r_idx == IDX_W'(NUM_PAIRS-1));
  end

  // NOTE: shadow registers carry no reset; they are always reloaded in CAPT
  // before anything reads them, so a reset term would only add fan-out.
  always_ff @(posedge clk) begin
    if (r_state == CAPT) begin
      r_shadow_r <= bus.IR_R;
      r_shadow_l <= bus.IR_L;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_acc          <= '0;
      r_sum          <= '0;
      r_idx          <= '0;
      r_err_raw      <= '0;
      r_error        <= '0;
      r_line_present <= 1'b0;
      r_err_vld      <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_err_vld <= 1'b0;
      // A strobe while busy is dropped; only the sticky flag records it.
      if (bus.IR_vld && (r_state != IDLE)) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (bus.IR_vld) r_state <= CAPT;
        CAPT: begin
          r_acc   <= '0;
          r_sum   <= '0;
          r_idx   <= '0;
          r_state <= ACCUM;
        end
        ACCUM: begin
          r_acc <= w_acc_next;
          r_sum <= w_sum_next;
          r_idx <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_err_raw      <= w_err_raw_next;
            r_line_present <= w_line_next;
            r_error        <= w_error_next;
            r_err_vld      <= 1'b1;
            r_state        <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.err_raw      = r_err_raw;
  assign bus.error        = r_error;
  assign bus.line_present = r_line_present;
  assign bus.err_vld      = r_err_vld;
  assign bus.busy         = (r_state != IDLE);
  assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_err_compute_n.sv
// -----------------------------------------------------------------------------
// tb_err_compute_n
// Directed vectors for err_compute_n (NUM_PAIRS=4, IR_W=12, ERR_W=16).
// Stimulus pushes the hand-computed result and the cycle it is due into a
// queue; a monitor on the falling edge pops and compares on every err_vld.
// -----------------------------------------------------------------------------
module tb_err_compute_n;

  localparam int NP = 4;
  localparam int IW = 12;
  localparam int EW = 16;

  typedef struct {
    logic [EW-1:0] raw;
    logic [EW-1:0] err;
    logic          lp;
    int            cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  err_compute_n_if #(.NUM_PAIRS(NP), .IR_W(IW), .ERR_W(EW)) bus ();

  err_compute_n #(
    .NUM_PAIRS (NP),
    .IR_W      (IW),
    .ERR_W     (EW),
    .LINE_THRES(16'h0200)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every err_vld must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.err_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_err_vld", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("latency",      32'(cyc),              32'(e.cyc));
        check("err_raw",      32'(bus.err_raw),      32'(e.raw));
        check("error",        32'(bus.error),        32'(e.err));
        check("line_present", 32'(bus.line_present), 32'(e.lp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One set: strobe at cycle k, optional stray strobe at k+2, readings
  // scrambled from k+2 on, result due at k+6, hold checked at k+7.
  task automatic send(input logic [NP*IW-1:0] r, input logic [NP*IW-1:0] l,
                      input logic [EW-1:0] opn, input logic [EW-1:0] raw,
                      input logic [EW-1:0] err, input logic lp,
                      input bit stray);
    exp_t e;
    e.raw = raw; e.err = err; e.lp = lp; e.cyc = cyc + NP + 2;
    sb_q.push_back(e);
    bus.IR_R       = r;
    bus.IR_L       = l;
    bus.err_opn_lp = opn;
    bus.IR_vld     = 1'b1;
    tick();
    bus.IR_vld = 1'b0;
    check("busy_in_capt", 32'(bus.busy), 32'd1);
    tick();
    bus.IR_R = {$urandom, $urandom};
    bus.IR_L = {$urandom, $urandom};
    if (stray) bus.IR_vld = 1'b1;
    tick();
    bus.IR_vld = 1'b0;
    repeat (4) tick();
    check("busy_idle_after", 32'(bus.busy), 32'd0);
    check("hold_err_raw", 32'(bus.err_raw), 32'(raw));
    check("hold_error",   32'(bus.error),   32'(err));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n          = 1'b0;
    bus.IR_vld     = 1'b0;
    bus.IR_R       = '0;
    bus.IR_L       = '0;
    bus.err_opn_lp = '0;
    repeat (3) tick();
    check("rst_err_raw", 32'(bus.err_raw),      32'd0);
    check("rst_error",   32'(bus.error),        32'd0);
    check("rst_lp",      32'(bus.line_present), 32'd0);
    check("rst_vld",     32'(bus.err_vld),      32'd0);
    check("rst_busy",    32'(bus.busy),         32'd0);
    check("rst_overrun", 32'(bus.overrun),      32'd0);
    rst_n = 1'b1;
    tick();

    // 0x100*15 = 0xF00, sum 0x400 > 0x200.
    send({NP{12'h100}}, '0, 16'hFF00, 16'h0F00, 16'h0F00, 1'b1, 1'b0);
    // 0xFFF*15 = 61425 saturates high; swapped saturates low.
    send({NP{12'hFFF}}, '0, 16'hFF00, 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
    send('0, {NP{12'hFFF}}, 16'hFF00, 16'h8000, 16'h8000, 1'b1, 1'b0);
    // No light: error follows the open-loop term.
    send('0, '0, 16'hFF00, 16'h0000, 16'hFF00, 1'b0, 1'b0);
    // Sum exactly 0x200 is absent; 0x201 is present.
    send({NP{12'h080}}, '0, 16'hFF00, 16'h0780, 16'hFF00, 1'b0, 1'b0);
    send({12'h080, 12'h080, 12'h080, 12'h081}, '0, 16'hFF00,
         16'h0781, 16'h0781, 1'b1, 1'b0);
    // Mixed signs: -48 -32 +64 +384 = 0x170, sum 0x140 -> no line.
    send({12'h040, 12'h030, 12'h020, 12'h010},
         {12'h010, 12'h020, 12'h030, 12'h040}, 16'h1234,
         16'h0170, 16'h1234, 1'b0, 1'b0);
    check("overrun_clear", 32'(bus.overrun), 32'd0);

    // Stray strobe at T+2 is ignored and sets the sticky overrun.
    send({NP{12'h100}}, '0, 16'hFF00, 16'h0F00, 16'h0F00, 1'b1, 1'b1);
    repeat (3) tick();
    check("overrun_sticky", 32'(bus.overrun), 32'd1);

    // Reset at T+3 aborts the set: no pulse, outputs back to zero.
    bus.IR_R   = {NP{12'h0FF}};
    bus.IR_L   = '0;
    bus.IR_vld = 1'b1;
    tick();
    bus.IR_vld = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_err_raw", 32'(bus.err_raw),      32'd0);
    check("abort_error",   32'(bus.error),        32'd0);
    check("abort_lp",      32'(bus.line_present), 32'd0);
    check("abort_busy",    32'(bus.busy),         32'd0);
    check("abort_overrun", 32'(bus.overrun),      32'd0);
    repeat (8) tick();
    send({NP{12'h100}}, '0, 16'hFF00, 16'h0F00, 16'h0F00, 1'b1, 1'b0);

    repeat (10) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
